grant_bus_ctrl: RTL and testbench

//  Downstream consumer of the 5-agent fixed-priority arbiter grants. Locks onto the
//  one-hot granted agent, forwards that agent's data beats onto a shared bus through
//  a one-entry registered output stage (valid/ready), and pulses a per-agent release

---
 rtl/grant_bus_ctrl_if.sv | 33 +++
 rtl/grant_bus_ctrl.sv | 122 ++++++++++++
 tb/tb_grant_bus_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/grant_bus_ctrl_if.sv
// Agent-side and bus-side signal bundle for grant_bus_ctrl.
// The controller connects through the master modport; the arbiter/agents/bus
// sink environment connects through the slave modport.
interface grant_bus_ctrl_if #(
   parameter int NUM_AGENTS = 5,
   parameter int DATA_W     = 8
);
   logic [NUM_AGENTS-1:0]        gnt;
   logic [NUM_AGENTS-1:0]        ag_valid;
   logic [NUM_AGENTS*DATA_W-1:0] ag_data;
   logic [NUM_AGENTS-1:0]        ag_last;
   logic [NUM_AGENTS-1:0]        ag_ready;
   logic [NUM_AGENTS-1:0]        ag_release;
   logic                         bus_valid;
   logic [DATA_W-1:0]            bus_data;
   logic                         bus_last;
   logic [2:0]                   bus_owner;
   logic                         bus_ready;
   logic                         busy;
   logic                         gnt_err;

   modport master (
      input  gnt, ag_valid, ag_data, ag_last, bus_ready,
      output ag_ready, ag_release, bus_valid, bus_data, bus_last, bus_owner,
             busy, gnt_err
   );

   modport slave (
      output gnt, ag_valid, ag_data, ag_last, bus_ready,
      input  ag_ready, ag_release, bus_valid, bus_data, bus_last, bus_owner,
             busy, gnt_err
   );
endinterface

// File: rtl/grant_bus_ctrl.sv
// Grant-driven bus controller: locks onto the one-hot granted agent, forwards
// its beats through a one-entry registered output stage, ends the burst on the
// agent's last marker or after MAX_BURST beats, then pulses a release to the
// owner so the arbiter can re-arbitrate. Ownership is never preempted.
module grant_bus_ctrl #(
   parameter int NUM_AGENTS = 5,
   parameter int DATA_W     = 8,
   parameter int MAX_BURST  = 4
) (
   input logic             clock,
   input logic             reset,
   grant_bus_ctrl_if.master io
);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] XFER    = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [1:0]        state;
   logic [2:0]        owner;
   logic [CNT_W-1:0]  cnt;
   logic              gnt_err_q;
   logic              bus_valid_q;
   logic [DATA_W-1:0] bus_data_q;
   logic              bus_last_q;

   logic [2:0]        gnt_idx;
   logic              gnt_any;
   logic              gnt_multi;
   logic              owner_ready;
   logic              accept;
   logic              beat_last;
   logic [DATA_W-1:0] owner_data;

   // Grant decode: index of the granted agent and a multi-bit detector.
   // NOTE: every signal written in an always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         if (io.gnt[i]) gnt_idx = 3'(i);
      end
   end

   assign gnt_any   = |io.gnt;
   assign gnt_multi = (io.gnt & (io.gnt - NUM_AGENTS'(1))) != '0;

   // Owner may hand over a beat whenever the output stage is empty or draining.
   assign owner_ready = (state == XFER) && (!bus_valid_q || io.bus_ready);
   assign accept      = owner_ready && io.ag_valid[owner];
   assign owner_data  = io.ag_data[owner*DATA_W +: DATA_W];
   assign beat_last   = io.ag_last[owner] || (cnt == CNT_LAST);

   // Burst sequencing: lock, count beats, wait for the last handshake, release.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= '0;
         cnt       <= '0;
         gnt_err_q <= 1'b0;
      end else begin
         gnt_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  if (gnt_multi) begin
                     gnt_err_q <= 1'b1;
                  end else begin
                     owner <= gnt_idx;
                     cnt   <= '0;
                     state <= XFER;
                  end
               end
            end
            XFER: begin
               if (accept) begin
                  cnt <= cnt + CNT_W'(1);
                  if (beat_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus_valid_q && io.bus_ready) state <= RELEASE;
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // One-entry output register: load on accept, retire on bus_ready, else hold.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus_valid_q <= 1'b0;
         bus_data_q  <= '0;
         bus_last_q  <= 1'b0;
      end else if (accept) begin
         bus_valid_q <= 1'b1;
         bus_data_q  <= owner_data;
         bus_last_q  <= beat_last;
      end else if (io.bus_ready) begin
         bus_valid_q <= 1'b0;
      end
   end

   // Per-agent ready and release are routed only to the locked owner.
   always_comb begin
      io.ag_ready   = owner_ready ? (NUM_AGENTS'(1) << owner) : '0;
      io.ag_release = (state == RELEASE) ? (NUM_AGENTS'(1) << owner) : '0;
   end

   assign io.bus_valid = bus_valid_q;
   assign io.bus_data  = bus_data_q;
   assign io.bus_last  = bus_last_q;
   assign io.bus_owner = owner;
   assign io.busy      = (state != IDLE);
   assign io.gnt_err   = gnt_err_q;
endmodule

// File: tb/tb_grant_bus_ctrl.sv
// Self-checking bench for grant_bus_ctrl: a driver plays arbiter, agents and
// bus sink; expected bus beats and release pulses are queued when a burst is
// issued and a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_grant_bus_ctrl;
   localparam int NA = 5;
   localparam int DW = 8;
   localparam int MB = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [2:0]    owner;
   } beat_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   grant_bus_ctrl_if #(.NUM_AGENTS(NA), .DATA_W(DW)) io ();

   grant_bus_ctrl #(.NUM_AGENTS(NA), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clock (clock),
      .reset (reset),
      .io    (io)
   );

   beat_t         exp_q[$];
   int            rel_q[$];
   int            checks   = 0;
   int            failures = 0;
   logic [NA-1:0] owner_mask = '0;
   logic          allow_err  = 1'b0;
   int            last_owner = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bus_valid"},  io.bus_valid,  0);
      check({tag, "_bus_data"},   io.bus_data,   0);
      check({tag, "_bus_last"},   io.bus_last,   0);
      check({tag, "_bus_owner"},  io.bus_owner,  0);
      check({tag, "_busy"},       io.busy,       0);
      check({tag, "_gnt_err"},    io.gnt_err,    0);
      check({tag, "_ag_ready"},   io.ag_ready,   0);
      check({tag, "_ag_release"}, io.ag_release, 0);
   endtask

   task automatic idle_inputs();
      io.gnt       = '0;
      io.ag_valid  = '0;
      io.ag_data   = '0;
      io.ag_last   = '0;
      io.bus_ready = 1'b1;
   endtask

   // Asynchronous reset pulse; pending expectations die with the burst.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check_all_zero(tag);
      exp_q.delete();
      rel_q.delete();
      owner_mask = '0;
      last_owner = 0;
      idle_inputs();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // Monitor: bus handshakes, release pulses, stall stability, ready routing.
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic          prev_last;
      logic [NA-1:0] prev_rel;
      beat_t         b;
      int            r;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      prev_rel   = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev_stall = 1'b0;
            prev_rel   = '0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", io.bus_valid, 1);
               check("hold_data",  io.bus_data,  prev_data);
               check("hold_last",  io.bus_last,  prev_last);
            end
            if (io.bus_valid && !io.bus_ready) check("stall_ag_ready", io.ag_ready, 0);
            check("ready_non_owner", io.ag_ready & ~owner_mask, 0);
            if (!allow_err) check("gnt_err_quiet", io.gnt_err, 0);
            if (io.bus_valid && io.bus_ready) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_bus_beat");
               end else begin
                  b = exp_q.pop_front();
                  check("beat_data",  io.bus_data,  b.data);
                  check("beat_last",  io.bus_last,  b.last);
                  check("beat_owner", io.bus_owner, b.owner);
               end
            end
            if (prev_rel != '0) begin
               check("release_width", io.ag_release, 0);
            end else if (io.ag_release != '0) begin
               if (rel_q.size() == 0) begin
                  fail_now("unexpected_release");
               end else begin
                  r = rel_q.pop_front();
                  check("release_agent", io.ag_release, 32'(NA'(1) << r));
               end
            end
            prev_stall = io.bus_valid && !io.bus_ready;
            prev_data  = io.bus_data;
            prev_last  = io.bus_last;
            prev_rel   = io.ag_release;
         end
      end
   end

   // One ownership: grant agent o, which offers n beats (last marker at
   // last_pos, -1 for none). The bus must see the beats up to the first last
   // marker or MAX_BURST, whichever comes first, the final one flagged last.
   task automatic run_burst(input int o, input int n, input int last_pos, input int base,
                            input bit rand_ready, input bit rand_valid, input int stall_at,
                            input int gnt_move_at, input int abort_after, input bit check_lat);
      logic [DW-1:0] d [0:7];
      int  k, i, acc_n, cyc, hs_cyc;
      bit  acc, rel, done;
      for (int j = 0; j < 8; j++) d[j] = (base >= 0) ? DW'(base + j) : DW'($urandom);
      k = (last_pos >= 0) ? last_pos + 1 : n;
      if (k > MB) k = MB;
      for (int j = 0; j < k; j++) exp_q.push_back('{d[j], (j == k - 1), 3'(o)});
      rel_q.push_back(o);

      @(posedge clock);
      #1;
      io.gnt     = NA'(1) << o;
      owner_mask = NA'(1) << o;
      i = 0; acc_n = 0; cyc = 0; hs_cyc = -10; done = 0;
      while (!done) begin
         // drive agents (non-owners get ignored noise) and the bus sink
         io.ag_valid = NA'($urandom);
         io.ag_last  = NA'($urandom);
         io.ag_data  = {8'($urandom), 32'($urandom)};
         io.ag_valid[o] = (i < n) && (!rand_valid || ($urandom_range(0, 3) != 0));
         io.ag_data[o*DW +: DW] = (i < n) ? d[i] : '0;
         io.ag_last[o] = (i == last_pos);
         if (stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3) io.bus_ready = 1'b0;
         else io.bus_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;

         @(negedge clock);
         cyc++;
         acc = io.ag_valid[o] && io.ag_ready[o];
         rel = io.ag_release[o];
         if (check_lat && cyc == 2) begin
            check("lat_busy_after_lock", io.busy, 1);
            check("lat_bus_empty", io.bus_valid, 0);
         end
         if (check_lat && cyc == 3) check("lat_first_beat", io.bus_valid, 1);
         if (cyc >= 2 && acc_n < k)
            check("ag_ready_xfer", io.ag_ready[o], !io.bus_valid || io.bus_ready);
         if (acc_n >= k) check("ag_ready_after_burst", io.ag_ready[o], 0);
         if (rel) check("release_after_last_hs", cyc, hs_cyc + 1);
         if (io.bus_valid && io.bus_ready && io.bus_last) hs_cyc = cyc;

         @(posedge clock);
         #1;
         if (acc) begin
            acc_n++;
            i++;
         end
         if (rel) done = 1;
         if (abort_after > 0 && acc && acc_n == abort_after) begin
            check("abort_bus_valid_before", io.bus_valid, 1);
            do_reset("abort");
            return;
         end
         if (cyc > 300) begin
            fail_now("burst_timeout");
            do_reset("timeout");
            return;
         end
         if (gnt_move_at > 0 && cyc == gnt_move_at) io.gnt = 5'b00001;
      end
      idle_inputs();
      owner_mask = '0;
      last_owner = o;
      @(negedge clock);
      check("busy_after_release", io.busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      @(posedge clock);
      #1;
      reset = 1'b1;

      // agent2 two-beat burst, latency and release timing
      run_burst(2, 2, 1, 'hA1, 0, 0, 0, 0, 0, 1);
      // agent0 streams 6 beats with no marker, cut at MAX_BURST
      run_burst(0, 6, -1, 'h10, 0, 0, 0, 0, 0, 1);
      // agent4 burst with a three-cycle bus stall mid-burst
      run_burst(4, 4, 3, 'h40, 0, 0, 3, 0, 0, 0);

      // multi-bit grant in IDLE: error pulse, nothing latched
      @(posedge clock);
      #1;
      allow_err = 1'b1;
      io.gnt = 5'b00011;
      @(negedge clock);
      check("err_busy_pre", io.busy, 0);
      @(posedge clock);
      #1;
      io.gnt = '0;
      @(negedge clock);
      check("err_pulse", io.gnt_err, 1);
      check("err_busy", io.busy, 0);
      check("err_owner_unchanged", io.bus_owner, last_owner);
      @(negedge clock);
      check("err_pulse_end", io.gnt_err, 0);
      allow_err = 1'b0;
      run_burst(1, 3, 2, 'h21, 0, 0, 0, 0, 0, 0);

      // grant moves to agent0 mid-burst of agent3
      run_burst(3, 5, -1, 'h30, 0, 0, 0, 3, 0, 0);

      // reset mid-burst, then a clean burst
      run_burst(1, 4, -1, 'h50, 0, 0, 0, 0, 2, 0);
      run_burst(2, 2, 1, 'h60, 0, 0, 0, 0, 0, 1);

      // randomized bursts
      for (int t = 0; t < 40; t++) begin
         int o, n, lp, st, mv;
         o  = $urandom_range(0, NA - 1);
         n  = $urandom_range(1, 6);
         lp = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, n - 1);
         if (lp < 0 && n < MB) n = MB;
         st = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0;
         mv = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : 0;
         run_burst(o, n, lp, -1, 1, 1, st, mv, 0, 0);
      end

      repeat (3) @(negedge clock);
      check("exp_queue_drained", exp_q.size(), 0);
      check("rel_queue_drained", rel_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
